// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    // Latency counter holds RD_LAT up to 4; starvation counter holds STARVE_MAX up to 15.
    localparam int LAT_W    = $clog2(5);
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data has priority unless fetch has been starved STARVE_MAX times.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant,
    output logic                grant_d
);

    logic fetch_starved;

    always_comb begin
        fetch_starved = i_req && (starve_cnt == STARVE_W'(STARVE_MAX));
        grant_d       = d_req && !fetch_starved;
        grant         = i_req || d_req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and load/store, sequencing
// one registered access at a time and returning read data with a one-cycle ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic pick_grant;
    logic pick_d;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .starve_cnt(starve_q),
        .grant     (pick_grant),
        .grant_d   (pick_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            lat_q     <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The mem_* registers double as the operand latch: loaded at grant, presented in ISSUE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    state_d = ISSUE;
                    if (pick_d) begin
                        owner_d = OWN_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_we ? d_wdata : '0;
                        wmask_d = d_we ? d_wmask : '0;
                        if (!i_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_I;
                        addr_d   = i_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        starve_d = '0;
                    end
                end
            end
            ISSUE: begin
                we_d    = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
                if (we_q) begin
                    addr_d  = '0;
                    state_d = ACK;
                end else begin
                    lat_d   = LAT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                // Counter hits zero on this edge: mem_rdata is valid in this cycle.
                if (lat_q == LAT_W'(1)) begin
                    addr_d  = '0;
                    state_d = ACK;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            ACK: begin
                addr_d  = '0;
                we_d    = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_ack     = (state_q == ACK) && (owner_q == OWN_I);
    assign d_ack     = (state_q == ACK) && (owner_q == OWN_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the core's instruction-fetch port and its load/store port.
- Data requests have priority, because a pending load or store stalls the core. A starvation counter guarantees fetch progress.
- Sits between the core datapath and the memory inside top. It sequences the registered memory access and returns read data with a one-cycle acknowledge.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width (multiple of 8).
- RD_LAT, 1, memory read latency in cycles (legal 1..4): mem_rdata is valid RD_LAT cycles after the cycle mem_addr is driven.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  DATA_W  fetched word; held until the next i_ack.
- d_req  in  1  load/store request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  byte enables for a store.
- d_ack  out  1  one-cycle pulse.
- d_rdata  out  DATA_W  load data; held until the next d_ack.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered write strobe.
- mem_wdata  out  DATA_W  registered write data.
- mem_wmask  out  DATA_W/8  registered byte mask.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs go to 0 immediately, state goes to IDLE and starve_cnt goes to 0. Reset asserted mid-transaction aborts it: no ack is issued and mem_we drops at once.
- States are IDLE, ISSUE, WAIT and ACK.
- IDLE, arbitration in cycle N:
  - Grant data if d_req && !(i_req && starve_cnt==STARVE_MAX); otherwise grant fetch if i_req.
  - Latch the winner's operands and go to ISSUE. With no request, stay in IDLE.
- ISSUE, cycle N+1:
  - mem_addr, mem_we, mem_wdata and mem_wmask are driven from the latched values.
  - mem_we=1 only for a store, and only in this cycle. mem_wmask is 0 whenever mem_we is 0.
  - A store goes to ACK. A load or fetch loads the latency counter with RD_LAT and goes to WAIT.
- WAIT:
  - The counter decrements each cycle. mem_addr is held.
  - In cycle N+1+RD_LAT (counter reaches 0), mem_rdata is registered into the granted port's rdata register and the state goes to ACK.
- ACK: pulse the granted port's ack for one cycle, drive mem_* to 0, then return to IDLE.
- Latency from request to ack:
  - store: 2 cycles (ack in N+2);
  - load/fetch: RD_LAT+2 cycles (ack in N+2+RD_LAT).
- Back-to-back: a req sampled high in the cycle after its ack is a new transaction. No dead cycles beyond IDLE.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each data grant made while i_req is high.
  - It clears on any fetch grant, and when i_req is low at a data grant.
- Simultaneous i_req and d_req with starve_cnt < STARVE_MAX: data wins.
- d_we=1 with d_wmask=0: a full write cycle runs with mem_we=1 and mask 0, and d_ack is issued.
- Only the granted port's rdata register updates. The other port's rdata holds its value.
- Addresses pass through unmodified. Alignment is the requester's responsibility.
- Requests that change mid-transaction are ignored; only the operands latched at grant are used.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, ACK};
  - owner_t enum {OWN_I, OWN_D};
  - the localparam width of the latency counter, $clog2(5).
- One sub-module, mem_arb_pick: combinational winner select from i_req, d_req, starve_cnt and STARVE_MAX. It is separate so it can be unit-tested.
- The FSM, counters and registers stay in mem_port_arbiter.

Test Plan:
- Fetch only, RD_LAT=1: i_req=1, i_addr=0x10 at N, mem holds 0x00500093 at 0x10 → mem_addr=0x10 in N+1, i_ack=1 in N+3 with i_rdata=0x00500093, busy high N+1..N+3.
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mask=0xF → mem_we=1 only in N+1, d_ack in N+2. Then a load of 0x100 → d_rdata=0xDEADBEEF, and i_rdata is unchanged.
- Contention, STARVE_MAX=4: i_req and d_req both held continuously → grant order D,D,D,D,I,D,D,D,D,I, with starve_cnt reaching 4 before each I.
- RD_LAT=3 sweep: load from 0x20 → d_ack exactly 5 cycles after d_req, and the captured data is the mem_rdata sampled in cycle N+4.
- Reset mid-read: reset=0 asserted in WAIT → all outputs 0 immediately, no ack ever pulses, FSM in IDLE. After release, a pending i_req is serviced normally.
- Zero-mask store plus back-to-back: d_wmask=0 → mem_we=1 and mem_wmask=0, d_ack issued. A new d_req held after the ack starts its ISSUE 2 cycles after that ack.
